voice_alloc: RTL and testbench
==============================

VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter M, default 12: tuning-word (phase-increment) width in bits.
REQ-002 Parameter NV, default 4: number of voices; SHALL be a power of two, at least 2.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 note_valid  in  1  note request present.
REQ-006 note_ready  out  1  block can accept a request.
REQ-007 note_on  in  1  1 = note-on, 0 = note-off; qualified by note_valid.
REQ-008 note_inc  in  M  tuning word; also the match key for note-off.
REQ-009 voice_inc  out  NV*M  per-voice tuning word; voice k occupies bits [k*M +: M].
REQ-010 voice_gate  out  NV  per-voice gate; 1 = sounding.
REQ-011 full_evt  out  1  one-cycle pulse on a steal or a drop (see REQ-030/031).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEARCH and WRITE.
REQ-013 note_ready SHALL equal (state==IDLE) and (not reset).
REQ-014 A request SHALL transfer on the edge where note_valid and note_ready are both 1.
- On transfer, note_on and note_inc are captured.
- Next state is SEARCH with scan index 0.
REQ-015 SEARCH SHALL examine one voice per cycle, index 0 to NV-1, for exactly NV cycles, then go to WRITE.
REQ-016 WRITE SHALL update at most one voice, pulse full_evt if applicable, and return to IDLE, all in one cycle.
REQ-017 Latency: a request accepted at edge E0 SHALL have its outputs updated at edge E(NV+1); note_ready is high again after that edge.
REQ-018 Note-on target SHALL be chosen in this priority order:
- (a) the lowest-index gated voice whose voice_inc equals note_inc (retrigger);
- (b) otherwise the lowest-index voice with gate 0;
- (c) otherwise the no-free-voice rule (REQ-030/031).
REQ-019 Note-on write SHALL set the target voice_inc to note_inc and its gate to 1.
REQ-020 Note-off SHALL clear the gate of the lowest-index gated voice whose voice_inc equals note_inc.
- That voice's voice_inc is retained (release tail).
REQ-021 A note-off with no match SHALL change nothing and SHALL NOT pulse full_evt.
REQ-022 note_valid held while note_ready is 0 SHALL have no effect.
- Requesters must hold note_valid and request data stable until the transfer edge.
REQ-023 Voices not targeted SHALL hold their values in every state.

Reset
REQ-024 While reset is asserted:
- state = IDLE;
- scan index = 0;
- steal pointer = 0;
- voice_inc all 0;
- voice_gate all 0;
- full_evt = 0;
- note_ready = 0.
REQ-025 Reset asserted in SEARCH or WRITE SHALL discard the in-flight request with no partial voice update.
REQ-026 After reset deasserts, note_ready SHALL be 1 at the next evaluation.

Configuration
REQ-027 The feature SHALL be controlled by the macro VOICE_STEAL_EN.
REQ-028 Steal pointer: with VOICE_STEAL_EN defined, a log2(NV)-bit steal pointer exists.
REQ-029 Steal pointer wrap: the pointer increments by 1 after each steal and wraps from NV-1 to 0.
REQ-030 With VOICE_STEAL_EN defined, a note-on with all voices gated and no retrigger match SHALL:
- overwrite the voice at the steal pointer with note_inc, gate 1;
- pulse full_evt in WRITE.
REQ-031 Without VOICE_STEAL_EN, the same note-on SHALL be dropped: no voice change, full_evt pulses in WRITE, no steal pointer exists.

Structure
REQ-032 Package voice_pkg SHALL hold:
- default M and NV;
- the FSM state enum;
- the voice-index width constant, log2(NV).
REQ-033 Sub-module voice_slot SHALL hold one voice's inc/gate registers.
- It provides a load strobe and a gate-clear strobe.
- It exposes a combinational match (gated and inc equal) and a free flag.
- voice_alloc instantiates NV of these.

Verification
REQ-034 With M=12, NV=4:
- Reset release, then note-on 0x123 accepted at E0 -> voice0 inc=0x123, gate=1 at E5; note_ready low for E1..E5, high after E5.
- Four note-ons 0x100, 0x200, 0x300, 0x400 -> voices 0..3 gated with those incs; full_evt never pulses.
- All voices full, then note-on 0x500 -> with VOICE_STEAL_EN: voice0 inc=0x500 and full_evt pulses once; a second 0x600 lands in voice1. Without VOICE_STEAL_EN: no change and full_evt pulses once.
- Note-off 0x200 -> voice1 gate=0, inc still 0x200; a following note-on 0x777 lands in voice1.
- Note-on 0x300 while voice2 already holds 0x300 gated -> voice2 retriggered; no other voice changes.
- Reset pulsed on the cycle after note-on 0xABC is accepted -> all outputs 0; voice0 never receives 0xABC; note_ready returns to 1.

Source files
------------

// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared defaults, FSM state encoding and index-width helper for the voice allocator
package voice_pkg;

    localparam int M_DEFAULT  = 12;
    localparam int NV_DEFAULT = 4;
    localparam int VIDX_W     = $clog2(NV_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_WRITE  = 2'd2
    } voice_state_t;

    function automatic int idx_width(input int nv);
        return (nv < 2) ? 1 : $clog2(nv);
    endfunction

endpackage

// File: rtl/voice_slot.sv
// rtl/voice_slot.sv - one voice: tuning-word and gate registers with load/clear strobes and match/free flags
module voice_slot #(
    parameter int M = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [M-1:0] key,
    output logic [M-1:0] inc,
    output logic         gate,
    output logic         match,
    output logic         free
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc  <= '0;
            gate <= 1'b0;
        end else if (load) begin
            inc  <= key;
            gate <= 1'b1;
        end else if (clr) begin
            gate <= 1'b0;
        end
    end

    assign match = gate && (inc == key);
    assign free  = !gate;

endmodule

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - note-on/off voice allocator, one voice scanned per cycle
// Optional voice stealing when all voices are busy: define VOICE_STEAL_EN.
module voice_alloc
    import voice_pkg::*;
#(
    parameter int M  = M_DEFAULT,
    parameter int NV = NV_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            note_valid,
    output logic            note_ready,
    input  logic            note_on,
    input  logic [M-1:0]    note_inc,
    output logic [NV*M-1:0] voice_inc,
    output logic [NV-1:0]   voice_gate,
    output logic            full_evt
);

    localparam int IW = idx_width(NV);

    voice_state_t   state;
    logic [IW-1:0]  scan_idx;
    logic           req_on;
    logic [M-1:0]   req_inc;
    logic           hit_match;
    logic           hit_free;
    logic [IW-1:0]  match_idx;
    logic [IW-1:0]  free_idx;

    logic [NV-1:0]  slot_match;
    logic [NV-1:0]  slot_free;
    logic [NV-1:0]  slot_load;
    logic [NV-1:0]  slot_clr;

    logic           accept;
    logic           do_load;
    logic           do_clr;
    logic           no_free;
    logic [IW-1:0]  target;

    assign note_ready = (state == ST_IDLE) && !reset;
    assign accept     = note_valid && note_ready;

`ifdef VOICE_STEAL_EN
    logic [IW-1:0] steal_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steal_ptr <= '0;
        end else if (no_free) begin
            steal_ptr <= steal_ptr + IW'(1);
        end
    end
`endif

    // Write decision: retrigger beats free voice beats the no-free-voice rule.
    always_comb begin
        do_load = 1'b0;
        do_clr  = 1'b0;
        no_free = 1'b0;
        target  = match_idx;
        if (state == ST_WRITE) begin
            if (req_on) begin
                if (hit_match) begin
                    do_load = 1'b1;
                    target  = match_idx;
                end else if (hit_free) begin
                    do_load = 1'b1;
                    target  = free_idx;
                end else begin
                    no_free = 1'b1;
`ifdef VOICE_STEAL_EN
                    do_load = 1'b1;
                    target  = steal_ptr;
`endif
                end
            end else if (hit_match) begin
                do_clr = 1'b1;
                target = match_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            scan_idx  <= '0;
            req_on    <= 1'b0;
            req_inc   <= '0;
            hit_match <= 1'b0;
            hit_free  <= 1'b0;
            match_idx <= '0;
            free_idx  <= '0;
            full_evt  <= 1'b0;
        end else begin
            full_evt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_on    <= note_on;
                        req_inc   <= note_inc;
                        scan_idx  <= '0;
                        hit_match <= 1'b0;
                        hit_free  <= 1'b0;
                        match_idx <= '0;
                        free_idx  <= '0;
                        state     <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    // First hit wins, so the lowest index is kept.
                    if (slot_match[scan_idx] && !hit_match) begin
                        hit_match <= 1'b1;
                        match_idx <= scan_idx;
                    end
                    if (slot_free[scan_idx] && !hit_free) begin
                        hit_free <= 1'b1;
                        free_idx <= scan_idx;
                    end
                    if (scan_idx == IW'(NV - 1)) begin
                        scan_idx <= '0;
                        state    <= ST_WRITE;
                    end else begin
                        scan_idx <= scan_idx + IW'(1);
                    end
                end
                ST_WRITE: begin
                    full_evt <= no_free;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NV; k++) begin : g_voice
        assign slot_load[k] = do_load && (target == IW'(k));
        assign slot_clr[k]  = do_clr && (target == IW'(k));

        voice_slot #(.M(M)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (slot_load[k]),
            .clr   (slot_clr[k]),
            .key   (req_inc),
            .inc   (voice_inc[k*M +: M]),
            .gate  (voice_gate[k]),
            .match (slot_match[k]),
            .free  (slot_free[k])
        );
    end

endmodule

// File: tb/tb_voice_alloc.sv
// tb/tb_voice_alloc.sv - directed table-driven bench for voice_alloc (M=12, NV=4)
module tb_voice_alloc;

    localparam int M  = 12;
    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            note_valid;
    logic            note_ready;
    logic            note_on;
    logic [M-1:0]    note_inc;
    logic [NV*M-1:0] voice_inc;
    logic [NV-1:0]   voice_gate;
    logic            full_evt;

    int checks   = 0;
    int failures = 0;

    voice_alloc #(.M(M), .NV(NV)) dut (
        .clk        (clk),
        .reset      (reset),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_on    (note_on),
        .note_inc   (note_inc),
        .voice_inc  (voice_inc),
        .voice_gate (voice_gate),
        .full_evt   (full_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        on;
        logic [11:0] inc;
        logic [47:0] exp_inc;
        logic [3:0]  exp_gate;
        int          exp_full;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pk(input logic [11:0] v3, input logic [11:0] v2,
                                       input logic [11:0] v1, input logic [11:0] v0);
        return {v3, v2, v1, v0};
    endfunction

    task automatic send(input logic on, input logic [11:0] inc, output int nfull, output bit ok);
        int w;
        nfull = 0;
        ok    = 1'b0;
        w     = 0;
        @(negedge clk);
        while (!note_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!note_ready) return;
        note_valid = 1'b1;
        note_on    = on;
        note_inc   = inc;
        @(negedge clk);
        note_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (full_evt) nfull++;
            @(negedge clk);
        end
        ok = note_ready;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int  nfull;
        bit  ok;

        vecs[0]  = '{1'b1, 12'h100, pk(12'h000, 12'h000, 12'h000, 12'h100), 4'b0001, 0};
        vecs[1]  = '{1'b1, 12'h200, pk(12'h000, 12'h000, 12'h200, 12'h100), 4'b0011, 0};
        vecs[2]  = '{1'b1, 12'h300, pk(12'h000, 12'h300, 12'h200, 12'h100), 4'b0111, 0};
        vecs[3]  = '{1'b1, 12'h400, pk(12'h400, 12'h300, 12'h200, 12'h100), 4'b1111, 0};
        vecs[4]  = '{1'b0, 12'h200, pk(12'h400, 12'h300, 12'h200, 12'h100), 4'b1101, 0};
        vecs[5]  = '{1'b1, 12'h777, pk(12'h400, 12'h300, 12'h777, 12'h100), 4'b1111, 0};
        vecs[6]  = '{1'b1, 12'h300, pk(12'h400, 12'h300, 12'h777, 12'h100), 4'b1111, 0};
        vecs[7]  = '{1'b0, 12'h999, pk(12'h400, 12'h300, 12'h777, 12'h100), 4'b1111, 0};
`ifdef VOICE_STEAL_EN
        vecs[8]  = '{1'b1, 12'h500, pk(12'h400, 12'h300, 12'h777, 12'h500), 4'b1111, 1};
        vecs[9]  = '{1'b1, 12'h600, pk(12'h400, 12'h300, 12'h600, 12'h500), 4'b1111, 1};
        vecs[10] = '{1'b0, 12'h300, pk(12'h400, 12'h300, 12'h600, 12'h500), 4'b1011, 0};
        vecs[11] = '{1'b1, 12'hABA, pk(12'h400, 12'hABA, 12'h600, 12'h500), 4'b1111, 0};
        vecs[12] = '{1'b0, 12'h500, pk(12'h400, 12'hABA, 12'h600, 12'h500), 4'b1110, 0};
`else
        vecs[8]  = '{1'b1, 12'h500, pk(12'h400, 12'h300, 12'h777, 12'h100), 4'b1111, 1};
        vecs[9]  = '{1'b1, 12'h600, pk(12'h400, 12'h300, 12'h777, 12'h100), 4'b1111, 1};
        vecs[10] = '{1'b0, 12'h300, pk(12'h400, 12'h300, 12'h777, 12'h100), 4'b1011, 0};
        vecs[11] = '{1'b1, 12'hABA, pk(12'h400, 12'hABA, 12'h777, 12'h100), 4'b1111, 0};
        vecs[12] = '{1'b0, 12'h100, pk(12'h400, 12'hABA, 12'h777, 12'h100), 4'b1110, 0};
`endif

        reset      = 1'b1;
        note_valid = 1'b0;
        note_on    = 1'b0;
        note_inc   = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(note_ready), 64'd0);
        chk("reset_inc", 64'(voice_inc), 64'd0);
        chk("reset_gate", 64'(voice_gate), 64'd0);
        chk("reset_full", 64'(full_evt), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(note_ready), 64'd1);

        // Latency: accepted at E0, outputs change at E5.
        @(negedge clk);
        note_valid = 1'b1;
        note_on    = 1'b1;
        note_inc   = 12'h123;
        @(negedge clk);
        note_valid = 1'b0;
        chk("lat_ready_e0", 64'(note_ready), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat_ready_e%0d", k), 64'(note_ready), 64'd0);
            chk($sformatf("lat_gate_e%0d", k), 64'(voice_gate), 64'd0);
        end
        @(negedge clk);
        chk("lat_ready_e5", 64'(note_ready), 64'd1);
        chk("lat_gate_e5", 64'(voice_gate), 64'd1);
        chk("lat_inc_e5", 64'(voice_inc), 64'h123);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            send(vecs[i].on, vecs[i].inc, nfull, ok);
            chk($sformatf("v%0d_done", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d_inc", i), 64'(voice_inc), 64'(vecs[i].exp_inc));
            chk($sformatf("v%0d_gate", i), 64'(voice_gate), 64'(vecs[i].exp_gate));
            chk($sformatf("v%0d_full", i), 64'(nfull), 64'(vecs[i].exp_full));
        end

        // Reset one cycle after a note-on is accepted discards it.
        @(negedge clk);
        note_valid = 1'b1;
        note_on    = 1'b1;
        note_inc   = 12'hABC;
        @(negedge clk);
        note_valid = 1'b0;
        reset      = 1'b1;
        #1;
        chk("mid_reset_ready", 64'(note_ready), 64'd0);
        chk("mid_reset_inc", 64'(voice_inc), 64'd0);
        chk("mid_reset_gate", 64'(voice_gate), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nfull = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (full_evt) nfull++;
        end
        chk("mid_after_inc", 64'(voice_inc), 64'd0);
        chk("mid_after_gate", 64'(voice_gate), 64'd0);
        chk("mid_after_full", 64'(nfull), 64'd0);
        chk("mid_after_ready", 64'(note_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
